dmem_storebuf_ctrl: RTL and testbench
=====================================

Name: dmem_storebuf_ctrl

Overview:
Data-side memory controller between the ARM core's data port (MemWrite, DataAdr, WriteData, ReadData) and a slower, handshaked backing RAM.
- Stores are absorbed into a posted store buffer, so they do not stall the core.
- Loads hit in the buffer via youngest-match forwarding, or stall the core until a RAM read completes.
- Adds the Stall output the next core revision uses to freeze PC and register writes.

Parameters:
DEPTH, 4, store-buffer entries (power of 2, at least 2)
AW, 32, byte address width from the core

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
MemWrite  in  1  core store request (STR)
MemRead  in  1  core load request (LDR)
DataAdr  in  AW  core byte address; bits [1:0] ignored (word aligned)
WriteData  in  32  store data
ReadData  out  32  load data to the core
Stall  out  1  core must hold all request inputs stable while high
ram_req  out  1  backing-RAM request
ram_we  out  1  1 = write, 0 = read; valid with ram_req
ram_addr  out  AW-2  word address
ram_wdata  out  32  write data
ram_ack  in  1  single-cycle completion pulse; sampled only while ram_req=1
ram_rdata  in  32  read data; valid in the ram_ack cycle

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - buffer empty, FSM IDLE, ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0, ReadData=0, Stall=0.
  - Reset mid-transaction drops ram_req the next cycle and discards all buffered stores.
- Store, buffer not full: enqueue {DataAdr[AW-1:2], WriteData} at the clock edge; Stall=0 in that cycle.
- Store, buffer full:
  - Stall=1.
  - In the cycle a head pop occurs (ram_ack in WR), the enqueue proceeds and Stall=0. Pop and push share a cycle.
- Load forwarding:
  - All valid entries are compared against DataAdr[AW-1:2]; the youngest match wins.
  - On a hit, ReadData = that entry's data combinationally, Stall=0, zero added latency.
  - Duplicate addresses in the buffer are legal.
- Load miss:
  - Stall=1 immediately (combinational).
  - If the FSM is in IDLE, go to RD next cycle. If in WR, finish that write, then go to RD; a pending miss has priority over further drains.
- FSM states:
  - IDLE: buffer non-empty and no load miss -> WR.
  - WR: ram_req=1, ram_we=1, address and data from the head entry, held stable. On ram_ack, pop the head, then go to RD if a load miss is pending, else IDLE.
  - RD: ram_req=1, ram_we=0, ram_addr=DataAdr[AW-1:2]. On ram_ack, capture ram_rdata into rdata_q and go to RDONE.
  - RDONE: ReadData=rdata_q, Stall=0 (the core completes the load), then IDLE.
- Ordering and hazards:
  - Stores drain strictly in FIFO order.
  - An entry stays in the buffer, and stays forwardable, until its ram_ack. RAW hazards through RAM are therefore impossible.
- ReadData when no load is active: holds its last value.
- Simultaneous MemWrite and MemRead: illegal. RTL treats it as a store and flags a simulation assertion.
- Stall depends combinationally on MemRead/MemWrite/DataAdr and registered state only. There is no path from ram_* inputs to Stall except the full-buffer pop case.
- Counters: head and tail pointers wrap modulo DEPTH; a count register of log2(DEPTH)+1 bits distinguishes full from empty.

Decomposition:
- Package dmem_pkg:
  - state enum {IDLE, WR, RD, RDONE}
  - struct sb_entry_t {word address, data}
  - DEPTH default constant
- Sub-module store_fifo: circular buffer with push/pop/full/empty, plus a parallel match port returning hit and youngest-match data.
- The FSM and Stall logic stay in the top.

Test Plan:
- Store 0x7 to addr 0x64 then load 0x64 the next cycle, RAM ack held off -> ReadData=0x7 same cycle, Stall=0, ram_we write of word 0x19 issued afterwards.
- Store 1 then store 2 to addr 0x60, load 0x60 -> forwards 2 (youngest); RAM sees the two writes in order, data 1 then 2.
- Five back-to-back stores with DEPTH=4 and ram_ack 3 cycles after req -> fifth store Stall=1 until the first ack cycle, then accepted with no lost or reordered writes.
- Load miss at 0x80 with RAM preloaded 0xDEADBEEF, ack after 2 cycles -> Stall high for 4 cycles (RD x3, clearing in RDONE), ReadData=0xDEADBEEF.
- Load miss issued while a WR is in flight -> WR completes first, RD next, buffered stores behind it wait until RDONE.
- Reset asserted in WR with 3 entries buffered -> ram_req=0 the next cycle, buffer empty, a subsequent load to the buffered address goes to RAM.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-side store-buffer controller: FSM states,
// buffer entry layout and default sizing.
package dmem_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned WADDR_W  = ADDR_W - 2;
    localparam int unsigned DATA_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [WADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } sb_entry_t;

endpackage

// File: rtl/store_fifo.sv
// Circular posted-store buffer with a parallel address-match port that
// returns the youngest matching entry's data.
module store_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  sb_entry_t          push_entry_i,
    input  logic               pop_i,
    output sb_entry_t          head_o,
    output logic               full_o,
    output logic               empty_o,
    input  logic [WADDR_W-1:0] match_addr_i,
    output logic               match_hit_o,
    output logic [DATA_W-1:0]  match_data_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] idx;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[head_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= push_entry_i;
                tail_q        <= tail_q + PW'(1);
            end
            if (pop_i) begin
                head_q <= head_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk oldest to youngest so the last (youngest) match overrides.
    always_comb begin
        match_hit_o  = 1'b0;
        match_data_o = '0;
        idx          = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_q[idx].addr == match_addr_i)) begin
                match_hit_o  = 1'b1;
                match_data_o = mem_q[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_storebuf_ctrl.sv
// Data-port controller: posts stores into a buffer that drains to a
// handshaked RAM, forwards loads from the buffer, stalls the core on misses.
module dmem_storebuf_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic [AW-1:0] DataAdr,
    input  logic [31:0]   WriteData,
    output logic [31:0]   ReadData,
    output logic          Stall,
    output logic          ram_req,
    output logic          ram_we,
    output logic [AW-3:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic          ram_ack,
    input  logic [31:0]   ram_rdata
);

    state_e             state_q;
    logic [31:0]        rdata_q;
    logic [31:0]        last_q;
    logic [WADDR_W-1:0] word_addr;
    logic               is_store;
    logic               is_load;
    logic               hit;
    logic               miss;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push;
    logic [31:0]        fwd_data;
    sb_entry_t          head;
    sb_entry_t          new_entry;
    logic               unused_adr_bits;

    assign unused_adr_bits = ^DataAdr[1:0];
    assign word_addr       = WADDR_W'(DataAdr[AW-1:2]);
    assign is_store        = MemWrite;
    assign is_load         = MemRead && !MemWrite;
    assign miss            = is_load && !hit;
    assign pop             = (state_q == WR) && ram_ack;
    assign push            = is_store && (!full || pop);
    assign new_entry       = '{addr: word_addr, data: WriteData};

    store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (new_entry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty),
        .match_addr_i (word_addr),
        .match_hit_o  (hit),
        .match_data_o (fwd_data)
    );

    // The only RAM-side path into Stall is a head pop freeing a full buffer.
    assign Stall = (is_store && full && !pop) || (miss && (state_q != RDONE));

    always_comb begin
        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            WR: begin
                ram_req   = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = (AW-2)'(head.addr);
                ram_wdata = head.data;
            end
            RD: begin
                ram_req  = 1'b1;
                ram_addr = DataAdr[AW-1:2];
            end
            default: ;
        endcase
    end

    always_comb begin
        ReadData = last_q;
        if (state_q == RDONE) begin
            ReadData = rdata_q;
        end else if (is_load && hit) begin
            ReadData = fwd_data;
        end
    end

    // A pending miss outranks further drains once the current write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            last_q  <= '0;
        end else begin
            last_q <= ReadData;
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        state_q <= RD;
                    end else if (!empty) begin
                        state_q <= WR;
                    end
                end
                WR: begin
                    if (ram_ack) begin
                        state_q <= miss ? RD : IDLE;
                    end
                end
                RD: begin
                    if (ram_ack) begin
                        rdata_q <= ram_rdata;
                        state_q <= RDONE;
                    end
                end
                RDONE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(MemWrite && MemRead))
                else $error("dmem_storebuf_ctrl: simultaneous MemWrite and MemRead");
        end
    end

endmodule

// File: tb/tb_dmem_storebuf_ctrl.sv
// Randomised bench for dmem_storebuf_ctrl with a transaction-level model:
// pending-store queue, architectural memory image and a latency-driven RAM.
module tb_dmem_storebuf_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned NW    = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          MemWrite;
    logic          MemRead;
    logic [AW-1:0] DataAdr;
    logic [31:0]   WriteData;
    logic [31:0]   ReadData;
    logic          Stall;
    logic          ram_req;
    logic          ram_we;
    logic [AW-3:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_ack;
    logic [31:0]   ram_rdata;

    dmem_storebuf_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_ack   (ram_ack),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned w;
        logic [31:0] d;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    logic        mw, mr, rst;
    logic [31:0] adr, wd;
    int          lat, lat_cnt;
    bit          rand_lat;
    logic [31:0] mem  [NW];
    logic [31:0] arch [NW];
    ent_t        pend [$];
    ent_t        wlog [$];
    bit          rd_ack_prev;
    logic [31:0] last_rd;
    logic        s_stall, s_req, s_we, s_ack;
    logic [31:0] s_rd, s_wdata;
    logic [AW-3:0] s_addr;

    function automatic logic [31:0] init_val(input int unsigned w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Per-cycle comparison against the model, then advance the model past the edge.
    task automatic compare_update();
        bit          req_wr, req_rd, hit, ack_wr, ack_rd, exp_stall, accept;
        int unsigned w;
        s_stall = Stall; s_req = ram_req; s_we = ram_we; s_ack = ram_ack;
        s_rd = ReadData; s_wdata = ram_wdata; s_addr = ram_addr;
        if (rst) begin
            pend.delete();
            foreach (arch[i]) arch[i] = mem[i];
            rd_ack_prev = 1'b0;
            lat_cnt     = 0;
            last_rd     = '0;
            return;
        end
        req_wr = MemWrite;
        req_rd = MemRead && !MemWrite;
        w      = 32'(DataAdr[7:2]);
        hit    = 1'b0;
        foreach (pend[i]) if (pend[i].w == w) hit = 1'b1;
        ack_wr = ram_req && ram_we && ram_ack;
        ack_rd = ram_req && !ram_we && ram_ack;
        if (ram_req && ram_we) begin
            if (pend.size() == 0) fail("wr_without_pending");
            else begin
                chk("wr_addr", 32'(ram_addr), pend[0].w);
                chk("wr_data", ram_wdata, pend[0].d);
            end
        end
        if (ram_req && !ram_we) begin
            chk("rd_needed", 32'(req_rd && !hit), 32'd1);
            chk("rd_addr", 32'(ram_addr), w);
        end
        if (req_wr) begin
            exp_stall = (pend.size() == DEPTH) && !ack_wr;
            chk("st_stall", 32'(Stall), 32'(exp_stall));
        end else if (req_rd) begin
            exp_stall = !hit && !rd_ack_prev;
            chk("ld_stall", 32'(Stall), 32'(exp_stall));
            if (!exp_stall) begin
                chk("ld_data", ReadData, arch[w]);
                last_rd = arch[w];
            end
        end else begin
            chk("idle_stall", 32'(Stall), 32'd0);
            chk("idle_rdata", ReadData, last_rd);
        end
        accept      = req_wr && ((pend.size() < DEPTH) || ack_wr);
        rd_ack_prev = ack_rd;
        if (ram_req && ram_ack) begin
            if (ram_we) begin
                mem[ram_addr[5:0]] = ram_wdata;
                wlog.push_back('{w: 32'(ram_addr), d: ram_wdata});
                if (pend.size() > 0) pend.delete(0);
            end
            lat_cnt = 0;
            if (rand_lat) lat = $urandom_range(0, 4);
        end else if (ram_req) begin
            lat_cnt++;
        end
        if (accept) begin
            pend.push_back('{w: w, d: WriteData});
            arch[w] = WriteData;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        reset = rst; MemWrite = mw; MemRead = mr; DataAdr = adr; WriteData = wd;
        #1;
        ram_ack   = 1'b0;
        ram_rdata = '0;
        if (ram_req && !rst) begin
            ram_rdata = mem[ram_addr[5:0]];
            if (lat_cnt >= lat) ram_ack = 1'b1;
        end
        @(negedge clk);
        compare_update();
    endtask

    // Issue one core request and hold it until Stall drops; ncyc counts cycles.
    task automatic op(input bit st, input bit ld, input logic [31:0] a,
                      input logic [31:0] d, output int ncyc);
        mw = st; mr = ld; adr = a; wd = d;
        ncyc = 0;
        do begin
            step();
            ncyc++;
        end while (s_stall && ncyc < 100);
        if (s_stall) fail("op_timeout");
        mw = 1'b0; mr = 1'b0;
    endtask

    task automatic drain();
        int n;
        mw = 1'b0; mr = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while ((pend.size() != 0 || s_req) && n < 300);
        if (pend.size() != 0 || s_req) fail("drain_timeout");
    endtask

    initial begin
        int n;
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; DataAdr = '0; WriteData = '0;
        ram_ack = 1'b0; ram_rdata = '0;
        mw = 1'b0; mr = 1'b0; adr = '0; wd = '0; rst = 1'b1;
        lat = 1; lat_cnt = 0; rand_lat = 1'b0; rd_ack_prev = 1'b0; last_rd = '0;
        for (int i = 0; i < NW; i++) begin
            mem[i]  = init_val(i);
            arch[i] = mem[i];
        end
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_stall", 32'(s_stall), 32'd0);
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_we", 32'(s_we), 32'd0);
        chk("rst_addr", 32'(s_addr), 32'd0);
        chk("rst_wdata", s_wdata, 32'd0);
        chk("rst_rdata", s_rd, 32'd0);

        // Forward a just-posted store while the RAM write is held off.
        lat = 20;
        op(1, 0, 32'h64, 32'h7, n);
        chk("t1_st_cycles", n, 1);
        op(0, 1, 32'h64, 32'h0, n);
        chk("t1_fwd_cycles", n, 1);
        chk("t1_fwd_data", s_rd, 32'h7);
        n = 0;
        do begin step(); n++; end while (!(s_req && s_we) && n < 10);
        chk("t1_waddr", 32'(s_addr), 32'h19);
        chk("t1_wdata", s_wdata, 32'h7);
        lat = 1;
        drain();

        // Youngest-match forwarding, writes land in order.
        lat = 3;
        wlog.delete();
        op(1, 0, 32'h60, 32'h1, n);
        op(1, 0, 32'h60, 32'h2, n);
        op(0, 1, 32'h60, 32'h0, n);
        chk("t2_fwd_youngest", s_rd, 32'h2);
        drain();
        chk("t2_nwrites", wlog.size(), 2);
        chk("t2_w0_data", wlog[0].d, 32'h1);
        chk("t2_w1_data", wlog[1].d, 32'h2);
        chk("t2_w0_addr", wlog[0].w, 32'h18);

        // Fifth store into a full buffer waits for the first write ack.
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            op(1, 0, 32'h40 + 32'(4 * i), 32'h100 + 32'(i), n);
            chk("t3_nostall", n, 1);
        end
        op(1, 0, 32'h50, 32'h104, n);
        chk("t3_full_cycles", n, 2);
        chk("t3_accept_on_ack", 32'(s_ack), 32'd1);
        drain();
        chk("t3_nwrites", wlog.size(), 5);
        for (int i = 0; i < 5 && i < wlog.size(); i++) begin
            chk("t3_order_addr", wlog[i].w, 32'h10 + 32'(i));
            chk("t3_order_data", wlog[i].d, 32'h100 + 32'(i));
        end

        // Plain load miss with two-cycle RAM latency.
        mem[32'h20]  = 32'hDEAD_BEEF;
        arch[32'h20] = 32'hDEAD_BEEF;
        lat = 2;
        op(0, 1, 32'h80, 32'h0, n);
        chk("t4_cycles", n, 5);
        chk("t4_data", s_rd, 32'hDEAD_BEEF);

        // Miss behind an in-flight write; the second store waits for RDONE.
        lat = 3;
        wlog.delete();
        op(1, 0, 32'h44, 32'hA1, n);
        op(1, 0, 32'h48, 32'hA2, n);
        op(0, 1, 32'h90, 32'h0, n);
        chk("t5_cycles", n, 9);
        chk("t5_writes_before_rd", wlog.size(), 1);
        chk("t5_data", s_rd, init_val(32'h24));
        drain();
        chk("t5_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) chk("t5_second_write", wlog[1].d, 32'hA2);

        // Reset during a write discards the buffered stores.
        lat = 20;
        op(1, 0, 32'h50, 32'hB0, n);
        op(1, 0, 32'h54, 32'hB1, n);
        op(1, 0, 32'h58, 32'hB2, n);
        step();
        chk("t6_in_wr", 32'(s_req && s_we), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("t6_req_dropped", 32'(s_req), 32'd0);
        chk("t6_stall", 32'(s_stall), 32'd0);
        lat = 2;
        op(0, 1, 32'h50, 32'h0, n);
        chk("t6_miss_cycles", n, 5);
        chk("t6_ram_data", s_rd, 32'h104);

        // Randomised traffic over a small address window.
        rand_lat = 1'b1;
        for (int k = 0; k < 400; k++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            a = ((32'h10 + 32'($urandom_range(0, 15))) << 2) | 32'($urandom_range(0, 3));
            if (r < 5)      op(1, 0, a, $urandom, n);
            else if (r < 8) op(0, 1, a, 32'h0, n);
            else begin
                mw = 1'b0; mr = 1'b0;
                step();
            end
        end
        drain();
        for (int i = 0; i < NW; i++) chk("ram_image", mem[i], arch[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
